// File: rtl/mac_vector_feeder_if.sv
// Host-side bus of mac_vector_feeder: bank write port,
// run control and the valid/ready result port.
interface mac_vector_feeder_if #(
    parameter int N  = 8,
    parameter int L  = 8,
    parameter int AW = $clog2(L)
) ();
    logic                  wr_en;
    logic                  wr_sel;
    logic [AW-1:0]         wr_addr;
    logic signed [N-1:0]   wr_data;
    logic                  start;
    logic [AW:0]           len;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic signed [2*N-1:0] res_data;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output start, len, res_ready,
        input  busy, res_valid, res_data
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  start, len, res_ready,
        output busy, res_valid, res_data
    );
endinterface

// File: rtl/mac_vector_feeder.sv
// Streams (W[i], X[i]) pairs from two local banks into an
// external MAC and returns the accumulated dot product.
module mac_vector_feeder #(
    parameter int N  = 8,
    parameter int L  = 8,
    parameter int AW = $clog2(L)
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_vector_feeder_if.slave    bus,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic signed [N-1:0]   mac_w,
    output logic signed [N-1:0]   mac_x,
    input  logic signed [2*N-1:0] mac_acc
);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LMAX = CW'(L);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt_max;
    logic [CW-1:0]         idx;
    logic                  busy;
    logic                  res_valid;
    logic signed [2*N-1:0] res_data;

    logic signed [N-1:0] w_bank [L];
    logic signed [N-1:0] x_bank [L];

    logic          wr_ok;
    logic [AW-1:0] rd_addr;

    assign wr_ok   = bus.wr_en && !busy && (int'(bus.wr_addr) < L);
    assign rd_addr = idx[AW-1:0];

    assign bus.busy      = busy;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;

    // Bank storage: writes accepted only while no run is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                w_bank[i] <= '0;
                x_bank[i] <= '0;
            end
        end else if (wr_ok) begin
            if (bus.wr_sel)
                x_bank[bus.wr_addr] <= bus.wr_data;
            else
                w_bank[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Run sequencer; idx always points at the next pair to issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt_max   <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_w     <= '0;
            mac_x     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt_max <= (bus.len > LMAX) ? LMAX : bus.len;
                        idx     <= '0;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    mac_clr <= 1'b0;
                    if (cnt_max == '0) begin
                        state <= DRAIN;
                    end else begin
                        mac_en <= 1'b1;
                        mac_w  <= w_bank[0];
                        mac_x  <= x_bank[0];
                        idx    <= CW'(1);
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (idx == cnt_max) begin
                        mac_en <= 1'b0;
                        mac_w  <= '0;
                        mac_x  <= '0;
                        state  <= DRAIN;
                    end else begin
                        mac_w <= w_bank[rd_addr];
                        mac_x <= x_bank[rd_addr];
                        idx   <= idx + CW'(1);
                    end
                end
                DRAIN: begin
                    res_data  <= mac_acc;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_vector_feeder.sv
// Randomized scenario bench for mac_vector_feeder with a
// behavioural MAC and a dot-product reference model.
module tb_mac_vector_feeder;
    localparam int N  = 8;
    localparam int L  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mac_clr, mac_en;
    logic signed [N-1:0]   mac_w, mac_x;
    logic signed [2*N-1:0] mac_acc;

    int n_tests = 0;
    int n_fail  = 0;
    int refw [L];
    int refx [L];

    mac_vector_feeder_if #(.N(N), .L(L), .AW(AW)) bus ();

    mac_vector_feeder #(.N(N), .L(L), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .mac_w   (mac_w),
        .mac_x   (mac_x),
        .mac_acc (mac_acc)
    );

    always #5 clk = ~clk;

    // Stand-in for the external MAC: reset by rst | mac_clr, wraps at 2N
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mac_acc <= '0;
        else if (mac_clr)
            mac_acc <= '0;
        else if (mac_en)
            mac_acc <= mac_acc + 16'(mac_w) * 16'(mac_x);
    end

    function automatic logic signed [15:0] model_dot(input int l);
        int s;
        int n;
        s = 0;
        n = (l > L) ? L : l;
        for (int i = 0; i < n; i++)
            s += refw[i] * refx[i];
        return 16'(s);
    endfunction

    task automatic write_bank(input logic sel, input int addr,
                              input int data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = AW'(addr);
        bus.wr_data = N'(data);
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (addr < L) begin
            if (sel) refx[addr] = 32'(signed'(N'(data)));
            else     refw[addr] = 32'(signed'(N'(data)));
        end
    endtask

    task automatic run(input int l, input logic rdy, input logic wr,
                       input logic wsel, input int waddr, input int wdata,
                       output int lat, output int en_cnt,
                       output logic signed [15:0] data,
                       output logic clr0, output logic busy0,
                       output logic to);
        lat    = -1;
        en_cnt = 0;
        data   = '0;
        to     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len       = 4'(l);
        bus.res_ready = rdy;
        bus.wr_en     = wr;
        bus.wr_sel    = wsel;
        bus.wr_addr   = AW'(waddr);
        bus.wr_data   = N'(wdata);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        clr0  = mac_clr;
        busy0 = bus.busy;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mac_en) en_cnt++;
            if (bus.res_valid) begin
                lat  = k;
                data = bus.res_data;
                to   = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_tests++;
        if ({bus.busy, mac_clr, mac_en, mac_w, mac_x, bus.res_valid,
             bus.res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b clr=%b en=%b w=%0d x=%0d v=%b d=%0d required all 0",
                     bus.busy, mac_clr, mac_en, mac_w, mac_x,
                     bus.res_valid, bus.res_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            refw[i] = 0;
            refx[i] = 0;
        end
    endtask

    task automatic test_basic();
        int lat, en;
        logic signed [15:0] d;
        logic c0, b0, to;
        write_bank(1'b0, 0, -3);
        write_bank(1'b0, 1, 5);
        write_bank(1'b1, 0, 2);
        write_bank(1'b1, 1, -4);
        run(2, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL basic_timeout: res_valid never rose");
        end
        n_tests++;
        if ({c0, b0} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_e0: clr=%b busy=%b required 1 1", c0, b0);
        end
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 4", lat);
        end
        n_tests++;
        if (en !== 2) begin
            n_fail++;
            $display("FAIL basic_en_cycles: got %0d required 2", en);
        end
        n_tests++;
        if (d !== -16'sd26 || d !== model_dot(2)) begin
            n_fail++;
            $display("FAIL basic_data: got %0d required -26", d);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_handshake: valid=%b busy=%b required 0 0",
                     bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_len0();
        int lat, en;
        logic signed [15:0] d;
        logic c0, b0, to;
        run(0, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (lat !== 2 || en !== 0) begin
            n_fail++;
            $display("FAIL len0_timing: lat=%0d en=%0d required 2 0", lat, en);
        end
        n_tests++;
        if (d !== 16'sd0) begin
            n_fail++;
            $display("FAIL len0_data: got %0d required 0", d);
        end
    endtask

    task automatic test_wrap();
        int lat, en;
        logic signed [15:0] d;
        logic c0, b0, to;
        for (int i = 0; i < 2; i++) begin
            write_bank(1'b0, i, -128);
            write_bank(1'b1, i, -128);
        end
        run(2, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (d !== -16'sd32768 || d !== model_dot(2)) begin
            n_fail++;
            $display("FAIL wrap_data: got %0d required -32768", d);
        end
    endtask

    task automatic test_full_stall();
        int lat, en;
        logic signed [15:0] d;
        logic c0, b0, to;
        for (int i = 0; i < L; i++) begin
            write_bank(1'b0, i, i + 1);
            write_bank(1'b1, i, 1);
        end
        run(8, 1'b0, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (lat !== 10 || en !== 8 || d !== 16'sd36) begin
            n_fail++;
            $display("FAIL full_run: lat=%0d en=%0d d=%0d required 10 8 36",
                     lat, en, d);
        end
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== model_dot(8) ||
                mac_en !== 1'b0 || mac_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cyc=%0d v=%b d=%0d en=%b clr=%b required 1 36 0 0",
                         c, bus.res_valid, bus.res_data, mac_en, mac_clr);
            end
            bus.start   = (c == 1);
            bus.len     = 4'd8;
            bus.wr_en   = (c == 2);
            bus.wr_sel  = 1'b0;
            bus.wr_addr = '0;
            bus.wr_data = 8'sd99;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        n_tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 16'sd36) begin
            n_fail++;
            $display("FAIL stall_end: v=%b d=%0d required 1 36",
                     bus.res_valid, bus.res_data);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.busy, mac_clr} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_release: v=%b busy=%b clr=%b required 0 0 0",
                     bus.res_valid, bus.busy, mac_clr);
        end
        run(8, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (d !== model_dot(8) || d !== 16'sd36) begin
            n_fail++;
            $display("FAIL stall_rerun: got %0d required 36", d);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, en;
        logic signed [15:0] d;
        logic c0, b0, to;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len       = 4'd4;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (mac_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_streaming: en=%b required 1", mac_en);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, mac_clr, mac_en, mac_w, mac_x, bus.res_valid,
             bus.res_data} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b clr=%b en=%b w=%0d x=%0d v=%b d=%0d required all 0",
                     bus.busy, mac_clr, mac_en, mac_w, mac_x,
                     bus.res_valid, bus.res_data);
        end
        for (int i = 0; i < L; i++) begin
            refw[i] = 0;
            refx[i] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        run(4, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        n_tests++;
        if (d !== 16'sd0 || lat !== 6 || en !== 4) begin
            n_fail++;
            $display("FAIL midrun_after: d=%0d lat=%0d en=%0d required 0 6 4",
                     d, lat, en);
        end
    endtask

    task automatic test_clamp();
        int lat, en, lat8, en8;
        logic signed [15:0] d, d8;
        logic c0, b0, to;
        for (int i = 0; i < L; i++) begin
            write_bank(1'b0, i, $urandom_range(0, 255));
            write_bank(1'b1, i, $urandom_range(0, 255));
        end
        run(15, 1'b1, 1'b0, 1'b0, 0, 0, lat, en, d, c0, b0, to);
        run(8, 1'b1, 1'b0, 1'b0, 0, 0, lat8, en8, d8, c0, b0, to);
        n_tests++;
        if (en !== 8 || lat !== 10) begin
            n_fail++;
            $display("FAIL clamp_timing: en=%0d lat=%0d required 8 10", en, lat);
        end
        n_tests++;
        if (d !== model_dot(8) || d !== d8) begin
            n_fail++;
            $display("FAIL clamp_data: got %0d len8 %0d required %0d",
                     d, d8, model_dot(8));
        end
    endtask

    task automatic test_back_to_back();
        int lat, en, l, ln, wa, wd;
        logic signed [15:0] d, exp_d;
        logic c0, b0, to, wr, ws;
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 3; k++)
                write_bank(1'($urandom_range(0, 1)), $urandom_range(0, L - 1),
                           $urandom_range(0, 255));
            l  = $urandom_range(0, 15);
            ln = (l > L) ? L : l;
            wr = 1'($urandom_range(0, 1));
            ws = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, L - 1);
            wd = $urandom_range(0, 255);
            if (wr) begin
                if (ws) refx[wa] = 32'(signed'(N'(wd)));
                else    refw[wa] = 32'(signed'(N'(wd)));
            end
            exp_d = model_dot(l);
            run(l, 1'b1, wr, ws, wa, wd, lat, en, d, c0, b0, to);
            n_tests++;
            if (d !== exp_d || lat !== ln + 2 || en !== ln || to) begin
                n_fail++;
                $display("FAIL rand_run%0d: len=%0d d=%0d lat=%0d en=%0d required %0d %0d %0d",
                         t, l, d, lat, en, exp_d, ln + 2, ln);
            end
        end
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_sel    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_full_stall();
        test_reset_midrun();
        test_clamp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
